// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-requester round-robin arbiter with grant hold, explicit
// release and a hold-time watchdog. A registered priority pointer rotates the
// request vector ahead of a plain priority encoder, so no requester starves.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_IDLE  | no owner; arbitrate from ptr_q, also the turnaround cycle
//   S_GRANT | owner_q holds the resource until release, withdrawal or limit
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] req_i,
    input  logic       release_i,
    output logic [7:0] gnt_o,
    output logic [2:0] gnt_id_o,
    output logic       gnt_vld_o,
    output logic       timeout_o
);

    localparam int unsigned CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    // Counter value on the last permitted hold cycle; unused when MAX_HOLD is 0.
    localparam logic [CW-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
    localparam bit WD_EN = (MAX_HOLD != 0);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    ptr_q, ptr_d;
    logic [2:0]    owner_q, owner_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    gnt_q, gnt_d;
    logic [2:0]    gnt_id_q, gnt_id_d;
    logic          gnt_vld_q, gnt_vld_d;
    logic          timeout_q, timeout_d;

    logic [15:0]   req_dbl;
    logic [7:0]    req_rot;
    logic [2:0]    rot_enc;
    logic [2:0]    pick_idx;
    logic          owner_req;
    logic          wd_hit;
    logic          grant_end;

    // Rotate requests so ptr_q lands at bit 0, then take the lowest set bit.
    always_comb begin
        req_dbl  = {req_i, req_i};
        req_rot  = req_dbl[ptr_q +: 8];
        rot_enc  = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_enc = 3'(i);
            end
        end
        pick_idx = ptr_q + rot_enc;
    end

    // Grant-end causes; release outranks withdrawal, which outranks the limit.
    always_comb begin
        owner_req = req_i[owner_q];
        wd_hit    = WD_EN && (cnt_q == HOLD_LAST);
        grant_end = release_i || !owner_req || wd_hit;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        gnt_vld_d = gnt_vld_q;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    owner_d   = pick_idx;
                    gnt_d     = 8'b1 << pick_idx;
                    gnt_id_d  = pick_idx;
                    gnt_vld_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_GRANT;
                end else begin
                    gnt_d     = 8'h00;
                    gnt_id_d  = 3'd0;
                    gnt_vld_d = 1'b0;
                end
            end
            S_GRANT: begin
                if (grant_end) begin
                    // Only a pure watchdog revoke is flagged.
                    timeout_d = !release_i && owner_req;
                    gnt_d     = 8'h00;
                    gnt_id_d  = 3'd0;
                    gnt_vld_d = 1'b0;
                    ptr_d     = owner_q + 3'd1;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= 3'd0;
            owner_q   <= 3'd0;
            cnt_q     <= '0;
            gnt_q     <= 8'h00;
            gnt_id_q  <= 3'd0;
            gnt_vld_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            gnt_vld_q <= gnt_vld_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign gnt_id_o  = gnt_id_q;
    assign gnt_vld_o = gnt_vld_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Testbench for rr_arbiter8 with a watchdog limit of 4 cycles. A driver applies
// inputs, advances a behavioural model and queues the outputs expected after
// each clock edge; a monitor compares them against the DUT on the falling edge.
module tb_rr_arbiter8;

    localparam int MH = 4;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_vld;
    logic       timeout;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] id;
        logic       vld;
        logic       to;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    // Model state: owner index or -1, next-priority index, cycles held.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_to;

    rr_arbiter8 #(.MAX_HOLD(MH)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .req_i     (req),
        .release_i (rel),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .gnt_vld_o (gnt_vld),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_hold  = 0;
        m_to    = 1'b0;
    endtask

    // One clock edge of arbiter behaviour, from the rules in plain arithmetic.
    task automatic model_edge(input logic [7:0] r, input logic rl);
        m_to = 1'b0;
        if (m_owner < 0) begin
            for (int j = 0; j < 8; j++) begin
                int k;
                k = (m_ptr + j) % 8;
                if (r[k]) begin
                    m_owner = k;
                    m_hold  = 1;
                    break;
                end
            end
        end else begin
            bit done;
            done = rl || !r[m_owner] || (MH != 0 && m_hold == MH);
            if (done) begin
                m_to    = !rl && r[m_owner];
                m_ptr   = (m_owner + 1) % 8;
                m_owner = -1;
            end else begin
                m_hold++;
            end
        end
    endtask

    // Called at posedge+1: apply inputs, predict, wait for the edge, queue.
    task automatic step(input logic [7:0] r, input logic rl);
        exp_t e;
        req = r;
        rel = rl;
        model_edge(r, rl);
        e = '0;
        if (m_owner >= 0) begin
            e.gnt[m_owner] = 1'b1;
            e.id           = 3'(m_owner);
            e.vld          = 1'b1;
        end
        e.to = m_to;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if (gnt !== 8'h00 || gnt_id !== 3'd0 || gnt_vld !== 1'b0 || timeout !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got gnt=%h id=%0d vld=%b to=%b, want all zero",
                     name, gnt, gnt_id, gnt_vld, timeout);
        end
    endtask

    // Asynchronous reset asserted mid-cycle, checked before any clock edge.
    task automatic do_reset(input string name);
        rst = 1'b1;
        exp_q.delete();
        model_reset();
        #1;
        check_zero(name);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Monitor: one expected record per cycle, compared on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                n_cmp++;
                if (gnt !== e.gnt || gnt_id !== e.id || gnt_vld !== e.vld || timeout !== e.to) begin
                    n_err++;
                    $display("FAIL cycle@%0t: got gnt=%h id=%0d vld=%b to=%b, want gnt=%h id=%0d vld=%b to=%b",
                             $time, gnt, gnt_id, gnt_vld, timeout, e.gnt, e.id, e.vld, e.to);
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        rst = 1'b1;
        req = 8'hFF;
        rel = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_hold");
        rst = 1'b0;

        // First grant after reset goes to requester 0, then async reset mid-grant.
        step(8'hFF, 1'b0);
        step(8'hFF, 1'b0);
        do_reset("reset_midgrant");

        // Full rotation with a release one cycle after each grant.
        for (int k = 0; k < 9; k++) begin
            step(8'hFF, 1'b0);
            step(8'hFF, 1'b1);
        end

        // Pointer after granting 2 is 3, so requester 0 wins over 1.
        do_reset("reset_ptr");
        step(8'h04, 1'b0);
        step(8'h04, 1'b1);
        step(8'h03, 1'b0);
        step(8'h03, 1'b1);
        step(8'h03, 1'b0);
        step(8'h03, 1'b1);

        // Watchdog: requester 3 held with no release, revoked twice.
        step(8'h00, 1'b0);
        for (int k = 0; k < 12; k++) step(8'h08, 1'b0);

        // Release coinciding with the limit edge: no timeout pulse.
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);
        for (int k = 0; k < 4; k++) step(8'h08, 1'b0);
        step(8'h08, 1'b1);
        step(8'h00, 1'b0);

        // Withdrawal by owner 5 moves the pointer to 6.
        step(8'h20, 1'b0);
        step(8'h20, 1'b0);
        step(8'h00, 1'b0);
        step(8'h60, 1'b0);
        step(8'h60, 1'b1);
        step(8'h00, 1'b0);

        // Withdrawal on the limit edge: no timeout pulse.
        for (int k = 0; k < 4; k++) step(8'h02, 1'b0);
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // Release while idle is ignored.
        step(8'h00, 1'b1);
        step(8'h00, 1'b1);

        // Randomized traffic with sticky request patterns.
        r = 8'($urandom);
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                r = ($urandom_range(0, 1) == 0) ? 8'($urandom) : 8'($urandom & $urandom);
            end
            if ($urandom_range(0, 199) == 0) begin
                do_reset("reset_random");
            end
            step(r, ($urandom_range(0, 3) == 0));
        end

        step(8'h00, 1'b0);
        @(negedge clk);
        #1;
        n_cmp++;
        if (exp_q.size() != 0 || n_cmp < 300) begin
            n_err++;
            $display("FAIL drain: got %0d pending, %0d compared; want 0 pending, at least 300",
                     exp_q.size(), n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
